// File: rtl/vmem_seq.sv
// Vector load/store sequencer: takes over the data-memory port and walks
// one element per cycle, stalling the pipeline until the vector is moved.
module vmem_seq #(
   parameter int LANES  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req,
   input  logic                     memSrc,
   input  logic                     memWrite,
   input  logic [ADDR_W-1:0]        base_addr,
   input  logic [LANES*DATA_W-1:0]  vdata_in,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic                     mem_own,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic                     mem_we,
   output logic [DATA_W-1:0]        mem_wdata,
   output logic                     stall,
   output logic [LANES*DATA_W-1:0]  vdata_out,
   output logic                     done
);

   // state     | meaning
   // IDLE      | waiting for a vector request; scalar accesses pass through
   // STORE     | one element written per cycle, lane idx
   // LOAD      | address of lane idx issued; data of lane idx-1 captured
   // LOAD_LAST | no new address; data of the last lane captured
   // DONE      | one-cycle completion pulse, pipeline released

   localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int STRIDE = DATA_W / 8;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      STORE     = 3'd1,
      LOAD      = 3'd2,
      LOAD_LAST = 3'd3,
      DONE      = 3'd4
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [IDX_W-1:0]          r_idx;
   logic [ADDR_W-1:0]         r_base;
   logic [LANES*DATA_W-1:0]   r_vdata;
   logic [LANES*DATA_W-1:0]   r_vdata_out;
   logic                      w_accept;
   logic                      w_busy;
   logic [ADDR_W-1:0]         w_offset;
   logic [DATA_W-1:0]         w_lane;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_lane = '0;
      for (int i = 0; i < LANES; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_lane = r_vdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Byte offset wraps modulo 2^ADDR_W together with the base add.
   assign w_offset = ADDR_W'(r_idx) * ADDR_W'(STRIDE);

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_busy      = 1'b0;
      mem_we      = 1'b0;
      mem_wdata   = '0;
      mem_addr    = '0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (req && memSrc) begin
               w_accept    = 1'b1;
               w_state_nxt = memWrite ? STORE : LOAD;
            end
         end
         STORE: begin
            w_busy    = 1'b1;
            mem_we    = 1'b1;
            mem_wdata = w_lane;
            mem_addr  = r_base + w_offset;
            if (r_idx == LAST_IDX) begin
               w_state_nxt = DONE;
            end
         end
         LOAD: begin
            w_busy   = 1'b1;
            mem_addr = r_base + w_offset;
            if (r_idx == LAST_IDX) begin
               w_state_nxt = LOAD_LAST;
            end
         end
         LOAD_LAST: begin
            w_busy      = 1'b1;
            mem_addr    = r_base + w_offset;
            w_state_nxt = DONE;
         end
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // The accept-cycle stall is combinational on req, so it must be masked
   // while reset holds the state register.
   assign stall     = w_busy | (w_accept & ~rst);
   assign mem_own   = w_busy;
   assign vdata_out = r_vdata_out;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx       <= '0;
         r_base      <= '0;
         r_vdata     <= '0;
         r_vdata_out <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req && memSrc) begin
                  r_base  <= base_addr;
                  r_vdata <= vdata_in;
                  r_idx   <= '0;
               end
            end
            STORE: begin
               r_idx <= r_idx + IDX_W'(1);
            end
            LOAD: begin
               for (int i = 0; i < LANES - 1; i++) begin
                  if (r_idx == IDX_W'(i + 1)) begin
                     r_vdata_out[i*DATA_W +: DATA_W] <= mem_rdata;
                  end
               end
               if (r_idx != LAST_IDX) begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            LOAD_LAST: begin
               r_vdata_out[(LANES-1)*DATA_W +: DATA_W] <= mem_rdata;
               r_idx <= '0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vmem_seq.sv
// Bench for vmem_seq: memory model plus write/load scoreboards, one task per scenario.
module tb_vmem_seq;
   localparam int LANES  = 4;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int VW     = LANES * DATA_W;

   logic              clk;
   logic              rst;
   logic              req;
   logic              memSrc;
   logic              memWrite;
   logic [ADDR_W-1:0] base_addr;
   logic [VW-1:0]     vdata_in;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_own;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic              stall;
   logic [VW-1:0]     vdata_out;
   logic              done;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   wr_t          wq[$];
   logic [VW-1:0] lq[$];
   logic [31:0]  mem [logic [31:0]];
   logic [31:0]  r_rd;

   vmem_seq #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .req(req), .memSrc(memSrc), .memWrite(memWrite),
      .base_addr(base_addr), .vdata_in(vdata_in), .mem_rdata(mem_rdata),
      .mem_own(mem_own), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .stall(stall), .vdata_out(vdata_out), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read data memory: data for an address appears next cycle.
   always @(posedge clk) begin
      if (mem_we === 1'b1) mem[mem_addr] = mem_wdata;
      r_rd <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
   end
   assign mem_rdata = r_rd;

   // Write scoreboard: every observed write must match the next expected one.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wr_t e;
         n_cmp++;
         if (wq.size() == 0) begin
            n_err++;
            $display("FAIL wr_unexpected got addr=%h data=%h required no write", mem_addr, mem_wdata);
         end else begin
            e = wq.pop_front();
            if (mem_addr !== e.a || mem_wdata !== e.d) begin
               n_err++;
               $display("FAIL wr_data got addr=%h data=%h required addr=%h data=%h",
                        mem_addr, mem_wdata, e.a, e.d);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "timeout");
   end

   task automatic run_op(input string tag, input logic wr, input logic [31:0] base,
                         input logic [VW-1:0] vec, input bit keep, input logic nwr,
                         input logic [31:0] nbase, input logic [VW-1:0] nvec);
      int lat;
      logic [VW-1:0] ev;
      logic [VW-1:0] got_v;
      lat = wr ? LANES + 1 : LANES + 2;
      @(negedge clk);
      req = 1'b1; memSrc = 1'b1; memWrite = wr; base_addr = base; vdata_in = vec;
      ev = '0;
      for (int i = 0; i < LANES; i++) begin
         logic [31:0] a;
         a = base + 32'(i * 4);
         if (wr) wq.push_back('{a: a, d: vec[i*DATA_W +: DATA_W]});
         else    ev[i*DATA_W +: DATA_W] = mem.exists(a) ? mem[a] : 32'h0;
      end
      if (!wr) lq.push_back(ev);
      #1;
      n_cmp++;
      if (stall !== 1'b1) begin
         n_err++; $display("FAIL %s accept_stall got=%b required=1", tag, stall);
      end
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         if (k == 1) begin
            if (keep) begin
               memWrite = nwr; base_addr = nbase; vdata_in = nvec;
            end else begin
               req = 1'b0; base_addr = 32'hDEAD_BEE0; vdata_in = ~vec;
            end
         end
         #1;
         n_cmp++;
         if (stall !== (k < lat)) begin
            n_err++; $display("FAIL %s stall k=%0d got=%b required=%b", tag, k, stall, k < lat);
         end
         n_cmp++;
         if (mem_own !== (k < lat)) begin
            n_err++; $display("FAIL %s mem_own k=%0d got=%b required=%b", tag, k, mem_own, k < lat);
         end
         n_cmp++;
         if (done !== (k == lat)) begin
            n_err++; $display("FAIL %s done k=%0d got=%b required=%b", tag, k, done, k == lat);
         end
         n_cmp++;
         if (mem_we !== (wr && k <= LANES)) begin
            n_err++; $display("FAIL %s mem_we k=%0d got=%b required=%b", tag, k, mem_we, wr && k <= LANES);
         end
         if (k <= LANES || k == lat) begin
            logic [31:0] ea;
            ea = (k <= LANES) ? base + 32'((k - 1) * 4) : 32'h0;
            n_cmp++;
            if (mem_addr !== ea) begin
               n_err++; $display("FAIL %s mem_addr k=%0d got=%h required=%h", tag, k, mem_addr, ea);
            end
         end
         if (!wr && k == lat) begin
            ev = lq.pop_front();
            got_v = vdata_out;
            n_cmp++;
            if (got_v !== ev) begin
               n_err++; $display("FAIL %s vdata_out got=%h required=%h", tag, got_v, ev);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 1'b0; memSrc = 1'b0; memWrite = 1'b0;
      base_addr = '0; vdata_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (stall !== 1'b0)     begin n_err++; $display("FAIL rst_stall got=%b required=0", stall); end
      n_cmp++; if (mem_own !== 1'b0)   begin n_err++; $display("FAIL rst_mem_own got=%b required=0", mem_own); end
      n_cmp++; if (mem_we !== 1'b0)    begin n_err++; $display("FAIL rst_mem_we got=%b required=0", mem_we); end
      n_cmp++; if (mem_addr !== '0)    begin n_err++; $display("FAIL rst_mem_addr got=%h required=0", mem_addr); end
      n_cmp++; if (mem_wdata !== '0)   begin n_err++; $display("FAIL rst_mem_wdata got=%h required=0", mem_wdata); end
      n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL rst_done got=%b required=0", done); end
      n_cmp++; if (vdata_out !== '0)   begin n_err++; $display("FAIL rst_vdata_out got=%h required=0", vdata_out); end
      rst = 1'b0;
   endtask

   task automatic test_store();
      logic [VW-1:0] v;
      v = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
      run_op("vst", 1'b1, 32'h100, v, 1'b0, 1'b0, '0, '0);
      for (int i = 0; i < LANES; i++) begin
         logic [31:0] a;
         a = 32'h100 + 32'(i * 4);
         n_cmp++;
         if (!mem.exists(a) || mem[a] !== v[i*DATA_W +: DATA_W]) begin
            n_err++; $display("FAIL vst_mem addr=%h got=%h required=%h", a,
                              mem.exists(a) ? mem[a] : 32'h0, v[i*DATA_W +: DATA_W]);
         end
      end
      n_cmp++;
      if (vdata_out !== '0) begin
         n_err++; $display("FAIL vst_vdata_untouched got=%h required=0", vdata_out);
      end
   endtask

   task automatic test_load();
      logic [VW-1:0] exp_v;
      for (int i = 0; i < LANES; i++) mem[32'h200 + 32'(i * 4)] = 32'(i + 1);
      exp_v = {32'd4, 32'd3, 32'd2, 32'd1};
      run_op("vld", 1'b0, 32'h200, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      n_cmp++;
      if (vdata_out !== exp_v) begin
         n_err++; $display("FAIL vld_hold got=%h required=%h", vdata_out, exp_v);
      end
      run_op("vst_after_vld", 1'b1, 32'h300, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, '0, '0);
      n_cmp++;
      if (vdata_out !== exp_v) begin
         n_err++; $display("FAIL vst_keeps_vdata got=%h required=%h", vdata_out, exp_v);
      end
   endtask

   task automatic test_wrap();
      run_op("wrap", 1'b1, 32'hFFFF_FFF8, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, '0, '0);
      n_cmp++;
      if (!mem.exists(32'h4)) begin
         n_err++; $display("FAIL wrap_mem got no write at 0x4 required write");
      end
   endtask

   task automatic test_scalar();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         req = 1'b1; memSrc = 1'b0; memWrite = c[0]; base_addr = 32'h700; vdata_in = '1;
         #1;
         n_cmp++;
         if (stall !== 1'b0 || mem_own !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL scalar c=%0d got stall=%b own=%b we=%b done=%b required all 0",
                              c, stall, mem_own, mem_we, done);
         end
      end
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [VW-1:0] vx;
      for (int i = 0; i < LANES; i++) mem[32'h200 + 32'(i * 4)] = 32'(i + 11);
      vx = {$urandom, $urandom, $urandom, $urandom};
      run_op("b2b_vst", 1'b1, 32'h400, vx, 1'b1, 1'b0, 32'h200, '0);
      run_op("b2b_vld", 1'b0, 32'h200, '0, 1'b1, 1'b1, 32'h600, vx);
      run_op("b2b_vst2", 1'b1, 32'h600, vx, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic test_reset_mid();
      logic [VW-1:0] v;
      v = {32'h5555_0004, 32'h5555_0003, 32'h5555_0002, 32'h5555_0001};
      @(negedge clk);
      req = 1'b1; memSrc = 1'b1; memWrite = 1'b1; base_addr = 32'h500; vdata_in = v;
      wq.push_back('{a: 32'h500, d: v[31:0]});
      wq.push_back('{a: 32'h504, d: v[63:32]});
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (mem_we !== 1'b0 || mem_own !== 1'b0 || stall !== 1'b0 || mem_addr !== '0 ||
          mem_wdata !== '0 || done !== 1'b0) begin
         n_err++; $display("FAIL rstmid_outputs got we=%b own=%b stall=%b addr=%h wdata=%h done=%b required all 0",
                           mem_we, mem_own, stall, mem_addr, mem_wdata, done);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         n_cmp++;
         if (done !== 1'b0 || stall !== 1'b0 || mem_own !== 1'b0) begin
            n_err++; $display("FAIL rstmid_after c=%0d got done=%b stall=%b own=%b required 0",
                              c, done, stall, mem_own);
         end
      end
      n_cmp++;
      if (vdata_out !== '0) begin
         n_err++; $display("FAIL rstmid_vdata got=%h required=0", vdata_out);
      end
      n_cmp++;
      if (wq.size() != 0 || mem.exists(32'h504) || mem.exists(32'h508) || !mem.exists(32'h500)) begin
         n_err++; $display("FAIL rstmid_writes got pending=%0d w504=%b w508=%b w500=%b required 0,0,0,1",
                           wq.size(), mem.exists(32'h504), mem.exists(32'h508), mem.exists(32'h500));
      end
      run_op("vld_after_rst", 1'b0, 32'h200, '0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_wrap();
      test_scalar();
      test_back_to_back();
      test_reset_mid();
      repeat (2) @(negedge clk);
      n_cmp++;
      if (wq.size() != 0) begin
         n_err++; $display("FAIL pending_writes got=%0d required=0", wq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
